// File: rtl/rc4_keystream_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc4_pkg                                                              |
// | Shared state encoding and sizing constants for the RC4 engine.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rc4_pkg;

  localparam int S_SIZE = 256;
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    K_RI,
    K_CI,
    K_CJ,
    K_WJ,
    P_I,
    P_CI,
    P_CJ,
    P_WJ,
    P_RK,
    P_CK,
    P_OUT,
    DONE
  } rc4_state_t;

endpackage
`default_nettype wire

// File: rtl/rc4_keystream_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc4_keystream_gen_if                                                 |
// | S-memory port and keystream valid/ready stream of the RC4 engine.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface rc4_keystream_gen_if;
  import rc4_pkg::*;

  logic [BYTE_W-1:0] ram_addr;
  logic [BYTE_W-1:0] ram_wdata;
  logic              ram_we;
  logic [BYTE_W-1:0] ram_rdata;
  logic              ks_valid;
  logic              ks_ready;
  logic [BYTE_W-1:0] ks_data;
  logic [15:0]       ks_index;

  modport master (
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata,
    output ks_valid,
    input  ks_ready,
    output ks_data, ks_index
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata,
    input  ks_valid,
    output ks_ready,
    input  ks_data, ks_index
  );

endinterface
`default_nettype wire

// File: rtl/rc4_keystream_gen_key_byte_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc4_key_byte_sel                                                     |
// | Picks key byte idx (MSB byte first) and the wrapped next index.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rc4_key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [BYTE_W-1:0]      byte_o,
  output logic [IDX_W-1:0]       idx_next_o
);

  always_comb begin
    byte_o = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (idx_i == IDX_W'(k)) begin
        byte_o = key_i[8*(KEY_BYTES-k)-1 -: 8];
      end
    end
  end

  // Compare-and-clear wrap keeps non-power-of-two key lengths cheap.
  assign idx_next_o = (idx_i == IDX_W'(KEY_BYTES - 1)) ? '0 : idx_i + IDX_W'(1);

endmodule
`default_nettype wire

// File: rtl/rc4_keystream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc4_keystream_gen                                                    |
// | RC4 KSA + PRGA engine driving an external 256x8 S-memory.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rc4_keystream_gen
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int INIT_S    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  rc4_keystream_gen_if.master    bus
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_IDX = BYTE_W'(S_SIZE - 1);

  rc4_state_t        state_q, state_d;
  logic [BYTE_W-1:0] i_q, i_d, j_q, j_d;
  logic [BYTE_W-1:0] si_q, si_d, sj_q, sj_d;
  logic [BYTE_W-1:0] ks_data_q, ks_data_d;
  logic [15:0]       count_q, count_d;
  logic [KIDX_W-1:0] kidx_q, kidx_d, kidx_next;
  logic [BYTE_W-1:0] key_byte, j_ksa, j_prga;
  logic [BYTE_W-1:0] addr_w, wdata_w;
  logic              we_w, valid_w;

  rc4_key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .IDX_W     (KIDX_W)
  ) u_key_sel (
    .key_i      (key),
    .idx_i      (kidx_q),
    .byte_o     (key_byte),
    .idx_next_o (kidx_next)
  );

  assign j_ksa  = j_q + bus.ram_rdata + key_byte;
  assign j_prga = j_q + bus.ram_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      ks_data_q <= '0;
      count_q   <= '0;
      kidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      ks_data_q <= ks_data_d;
      count_q   <= count_d;
      kidx_q    <= kidx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    ks_data_d = ks_data_q;
    count_d   = count_q;
    kidx_d    = kidx_q;
    addr_w    = '0;
    wdata_w   = '0;
    we_w      = 1'b0;
    valid_w   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (INIT_S != 0) ? INIT : K_RI;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          count_d = '0;
        end
      end
      INIT: begin
        we_w    = 1'b1;
        addr_w  = i_q;
        wdata_w = i_q;
        i_d     = i_q + 8'd1;
        if (i_q == LAST_IDX) state_d = K_RI;
      end
      K_RI: begin
        addr_w  = i_q;
        state_d = K_CI;
      end
      K_CI: begin
        si_d    = bus.ram_rdata;
        j_d     = j_ksa;
        addr_w  = j_ksa;
        state_d = K_CJ;
      end
      K_CJ: begin
        sj_d    = bus.ram_rdata;
        we_w    = 1'b1;
        addr_w  = i_q;
        wdata_w = bus.ram_rdata;
        state_d = K_WJ;
      end
      K_WJ: begin
        we_w    = 1'b1;
        addr_w  = j_q;
        wdata_w = si_q;
        i_d     = i_q + 8'd1;
        kidx_d  = kidx_next;
        // i wraps to 0 on its own; only j needs clearing for the PRGA.
        if (i_q == LAST_IDX) begin
          j_d     = '0;
          state_d = P_I;
        end else begin
          state_d = K_RI;
        end
      end
      P_I: begin
        i_d     = i_q + 8'd1;
        addr_w  = i_q + 8'd1;
        state_d = P_CI;
      end
      P_CI: begin
        si_d    = bus.ram_rdata;
        j_d     = j_prga;
        addr_w  = j_prga;
        state_d = P_CJ;
      end
      P_CJ: begin
        sj_d    = bus.ram_rdata;
        we_w    = 1'b1;
        addr_w  = i_q;
        wdata_w = bus.ram_rdata;
        state_d = P_WJ;
      end
      P_WJ: begin
        we_w    = 1'b1;
        addr_w  = j_q;
        wdata_w = si_q;
        state_d = P_RK;
      end
      P_RK: begin
        addr_w  = si_q + sj_q;
        state_d = P_CK;
      end
      P_CK: begin
        ks_data_d = bus.ram_rdata;
        state_d   = P_OUT;
      end
      P_OUT: begin
        valid_w = 1'b1;
        if (bus.ks_ready) begin
          count_d = count_q + 16'd1;
          state_d = (count_d == 16'(MSG_LEN)) ? DONE : P_I;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_addr  = addr_w;
  assign bus.ram_wdata = wdata_w;
  assign bus.ram_we    = we_w;
  assign bus.ks_valid  = valid_w;
  assign bus.ks_data   = ks_data_q;
  assign bus.ks_index  = count_q;
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_rc4_keystream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rc4_keystream_gen                                                 |
// | Directed bench with an array-based RC4 reference model.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rc4_keystream_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
  logic rdy;
  logic busy0, done0, busy1, done1, busy2, done2;
  logic [23:0] key0 = 24'h4B6579;
  logic [39:0] key1 = 40'h0102030405;
  logic [23:0] key2 = 24'h4B6579;

  always #5 clk = ~clk;

  rc4_keystream_gen_if if0 ();
  rc4_keystream_gen_if if1 ();
  rc4_keystream_gen_if if2 ();

  rc4_keystream_gen #(.KEY_BYTES(3), .MSG_LEN(10), .INIT_S(1)) dut0 (
    .clk(clk), .reset(reset), .key(key0), .start(st0),
    .busy(busy0), .done(done0), .bus(if0));
  rc4_keystream_gen #(.KEY_BYTES(5), .MSG_LEN(8), .INIT_S(1)) dut1 (
    .clk(clk), .reset(reset), .key(key1), .start(st1),
    .busy(busy1), .done(done1), .bus(if1));
  rc4_keystream_gen #(.KEY_BYTES(3), .MSG_LEN(10), .INIT_S(0)) dut2 (
    .clk(clk), .reset(reset), .key(key2), .start(st2),
    .busy(busy2), .done(done2), .bus(if2));

  assign if0.ks_ready = rdy;
  assign if1.ks_ready = rdy;
  assign if2.ks_ready = rdy;

  // S-memories: synchronous write, synchronous 1-cycle read
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];

  always @(posedge clk) begin
    if (if0.ram_we) mem0[if0.ram_addr] <= if0.ram_wdata;
    if0.ram_rdata <= mem0[if0.ram_addr];
    if (if1.ram_we) mem1[if1.ram_addr] <= if1.ram_wdata;
    if1.ram_rdata <= mem1[if1.ram_addr];
    if (if2.ram_we) mem2[if2.ram_addr] <= if2.ram_wdata;
    if2.ram_rdata <= mem2[if2.ram_addr];
  end

  // Selected-DUT view for the compare process
  int sel = 0;
  logic m_valid, m_busy, m_done;
  logic [7:0] m_data;
  logic [15:0] m_index;
  always_comb begin
    m_valid = if0.ks_valid; m_data = if0.ks_data; m_index = if0.ks_index;
    m_busy = busy0; m_done = done0;
    case (sel)
      1: begin
        m_valid = if1.ks_valid; m_data = if1.ks_data; m_index = if1.ks_index;
        m_busy = busy1; m_done = done1;
      end
      2: begin
        m_valid = if2.ks_valid; m_data = if2.ks_data; m_index = if2.ks_index;
        m_busy = busy2; m_done = done2;
      end
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference RC4 over a plain integer array
  logic [7:0] ref_key [32];
  logic [7:0] ref_ks [64];

  task automatic compute_ref(input int klen, input int n);
    int s[256];
    int i, j, t;
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + s[k] + int'(ref_key[k % klen])) % 256;
      t = s[k]; s[k] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int k = 0; k < 64; k++) ref_ks[k] = 8'h00;
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ref_ks[k] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  task automatic load_key_text();
    ref_key[0] = 8'h4B; ref_key[1] = 8'h65; ref_key[2] = 8'h79;
  endtask

  // Ready driver: held high, or pseudo-random when rnd_mode is set
  bit rnd_mode = 1'b0;
  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      rdy = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Compare process
  bit chk_en = 1'b0;
  int cur_n = 0;
  int exp_idx = 0;
  bit stalled = 1'b0;
  bit last_hs = 1'b0;
  logic [7:0] hold_d;
  logic [15:0] hold_i;

  always @(negedge clk) begin
    if (!chk_en) begin
      exp_idx = 0; stalled = 1'b0; last_hs = 1'b0;
    end else begin
      last_hs = 1'b0;
      if (m_valid) begin
        check("extra_byte", 32'(exp_idx < cur_n), 32'd1);
        check("ks_index", 32'(m_index), 32'(exp_idx));
        if (exp_idx < 64) check("ks_data", 32'(m_data), 32'(ref_ks[exp_idx]));
        if (stalled) begin
          check("stall_hold_data", 32'(m_data), 32'(hold_d));
          check("stall_hold_index", 32'(m_index), 32'(hold_i));
        end
        if (rdy) begin
          exp_idx++; stalled = 1'b0; last_hs = 1'b1;
        end else begin
          stalled = 1'b1; hold_d = m_data; hold_i = m_index;
        end
      end else if (stalled) begin
        check("valid_dropped", 32'(m_valid), 32'd1);
        stalled = 1'b0;
      end
    end
  end

  task automatic set_start(input logic v);
    case (sel)
      1: st1 = v;
      2: st2 = v;
      default: st0 = v;
    endcase
  endtask

  task automatic run_case(input int s, input int n, input int exp_lat, input bit hold);
    int lat, cnt;
    chk_en = 1'b0;
    sel = s;
    cur_n = n;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    set_start(1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_start(1'b0);
    lat = 0;
    while (!m_valid && lat < 3000) begin
      @(posedge clk); #1; lat++;
    end
    check("first_valid_seen", 32'(m_valid), 32'd1);
    check("first_valid_latency", 32'(lat), 32'(exp_lat));
    check("busy_while_running", 32'(m_busy), 32'd1);
    cnt = 0;
    while (!m_done && cnt < 4000) begin
      @(posedge clk); #1; cnt++;
    end
    check("done_seen", 32'(m_done), 32'd1);
    check("bytes_at_done", 32'(exp_idx), 32'(n));
    check("done_after_last_hs", 32'(last_hs), 32'd1);
    check("busy_in_done", 32'(m_busy), 32'd0);
  endtask

  task automatic check_dut0_zero(input string tag);
    check({tag, "_busy"},   32'(busy0), 32'd0);
    check({tag, "_done"},   32'(done0), 32'd0);
    check({tag, "_we"},     32'(if0.ram_we), 32'd0);
    check({tag, "_addr"},   32'(if0.ram_addr), 32'd0);
    check({tag, "_wdata"},  32'(if0.ram_wdata), 32'd0);
    check({tag, "_valid"},  32'(if0.ks_valid), 32'd0);
    check({tag, "_data"},   32'(if0.ks_data), 32'd0);
    check({tag, "_index"},  32'(if0.ks_index), 32'd0);
  endtask

  logic [7:0] lit_a [10];
  logic [7:0] lit_b [8];

  initial begin
    lit_a = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    lit_b = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27};
    for (int n = 0; n < 256; n++) mem2[n] = 8'(n);

    // Reset state
    #12;
    check_dut0_zero("reset");
    check("reset_busy1", 32'(busy1), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Pin the model against published vectors
    ref_key[0] = 8'h01; ref_key[1] = 8'h02; ref_key[2] = 8'h03;
    ref_key[3] = 8'h04; ref_key[4] = 8'h05;
    compute_ref(5, 8);
    for (int k = 0; k < 8; k++) check("model_pin_0102030405", 32'(ref_ks[k]), 32'(lit_b[k]));
    load_key_text();
    compute_ref(3, 10);
    for (int k = 0; k < 10; k++) check("model_pin_Key", 32'(ref_ks[k]), 32'(lit_a[k]));

    // "Key", ready held high
    run_case(0, 10, 1286, 1'b0);

    // 5-byte key
    ref_key[0] = 8'h01; ref_key[1] = 8'h02; ref_key[2] = 8'h03;
    ref_key[3] = 8'h04; ref_key[4] = 8'h05;
    compute_ref(5, 8);
    run_case(1, 8, 1286, 1'b0);

    // "Key" with random backpressure
    load_key_text();
    compute_ref(3, 10);
    rnd_mode = 1'b1;
    run_case(0, 10, 1286, 1'b0);
    rnd_mode = 1'b0;

    // Reset 500 cycles into the KSA, then restart
    chk_en = 1'b0;
    sel = 0;
    repeat (2) @(negedge clk);
    st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    repeat (256 + 500) @(posedge clk);
    #1;
    check("busy_before_abort", 32'(busy0), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_dut0_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check_dut0_zero("held_reset");
    @(negedge clk);
    reset = 1'b0;
    run_case(0, 10, 1286, 1'b0);

    // start held through DONE
    run_case(0, 10, 1286, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("held_start_done", 32'(done0), 32'd1);
      check("held_start_busy", 32'(busy0), 32'd0);
    end
    st0 = 1'b0;
    @(posedge clk); #1;
    check("idle_after_release_done", 32'(done0), 32'd0);
    check("idle_after_release_busy", 32'(busy0), 32'd0);
    run_case(0, 10, 1286, 1'b0);

    // Preloaded S, no INIT phase
    run_case(2, 10, 1030, 1'b0);

    chk_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc4_keystream_gen.md
# rc4_keystream_gen

Parametrised RC4 keystream engine: the next-generation RC4 core for the decryption datapath. It drives an external 256×8 S-memory through the KSA (with optional S[i]=i initialisation) using a key of configurable length. It then streams MSG_LEN PRGA keystream bytes to the downstream XOR/decrypt stage over a valid/ready handshake with backpressure.

## Interface
- KEY_BYTES, 3: key length in bytes (1..32); key width is 8*KEY_BYTES.
- MSG_LEN, 32: keystream bytes produced per run (1..65535).
- INIT_S, 1: 1 runs the 256-cycle S[i]=i fill; 0 skips it (S preloaded externally).
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are `clk` and `reset`.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- key  in  8*KEY_BYTES  key. Byte k is key[8*(KEY_BYTES-k)-1 -: 8] (MSB byte first). It must be stable while busy.
- start  in  1  level request, accepted only in IDLE.
- busy  out  1  high from the cycle after acceptance until DONE.
- done  out  1  high in DONE.
- ram_addr  out  8  S-memory address.
- ram_wdata  out  8  S-memory write data.
- ram_we  out  1  S-memory write enable.
- ram_rdata  in  8  S-memory read data. Synchronous read, 1-cycle latency.
- ks_valid  out  1  keystream byte available.
- ks_ready  in  1  downstream accepts the byte.
- ks_data  out  8  keystream byte.
- ks_index  out  16  0-based index of ks_data within the run.

## Operation
- Reset value of every output is 0. State resets to IDLE; i, j, and counters reset to 0. S contents are not touched.
- IDLE: with start=1, go to INIT (INIT_S=1) or K_RI (INIT_S=0). Clear i=0, j=0, key index=0, byte count=0.
- INIT: write S[n]=n for n=0..255, one write per cycle (ram_we=1, ram_addr=ram_wdata=n). After n=255, go to K_RI.
- KSA, 4 states per i, i=0..255:
  - K_RI: addr=i.
  - K_CI: si=rdata. j=j+si+key[kidx] (mod 256). addr=new j.
  - K_CJ: sj=rdata. Write S[i]=sj.
  - K_WJ: write S[j]=si. Increment i. kidx wraps at KEY_BYTES-1→0, with no modulo operator. After i=255, set i=0, j=0, and go to P_I.
- PRGA, per byte:
  - P_I: i=i+1. addr=i+1.
  - P_CI: si=rdata. j=j+si. addr=new j.
  - P_CJ: sj=rdata. Write S[i]=sj.
  - P_WJ: write S[j]=si.
  - P_RK: addr=si+sj (mod 256).
  - P_CK: ks_data<=rdata.
  - P_OUT: ks_valid=1.
  - On ks_valid & ks_ready, increment the count. If count==MSG_LEN, go to DONE; otherwise go to P_I.
- i==j needs no special case: both writes store the same value.
- DONE: done=1, busy=0. Go to IDLE when start=0, so a held start does not auto-restart.
- start is ignored in every state except IDLE. reset mid-run aborts immediately to IDLE.
- All index and sum arithmetic is 8-bit wrap-around. The byte counter is 16-bit.

## Timing
- Start accepted at edge 0. INIT occupies cycles 1..256, KSA takes 1024 cycles, and the first PRGA byte takes 6 cycles.
- First ks_valid is asserted 1286 cycles after the accepting edge, or 1030 with INIT_S=0.
- Later bytes arrive every 7 cycles with ks_ready held high. Each cycle of ks_ready=0 adds one cycle.
- ks_data and ks_index are stable while ks_valid=1 and ks_ready=0. ks_valid never drops without a handshake.
- ram_we is high only in INIT, K_CJ, K_WJ, P_CJ, and P_WJ.
- done rises the cycle after the final handshake.

## Structure
- Package rc4_pkg holds:
  - the state enum `rc4_state_t` (IDLE, INIT, K_RI, K_CI, K_CJ, K_WJ, P_I, P_CI, P_CJ, P_WJ, P_RK, P_CK, P_OUT, DONE);
  - S_SIZE=256;
  - BYTE_W=8.
- Sub-module rc4_key_byte_sel selects key byte by a wrapping index (KEY_BYTES-parametrised). The FSM and datapath stay in rc4_keystream_gen.

## Test plan
- KEY_BYTES=3, key=24'h4B6579 ("Key"), MSG_LEN=10, ks_ready=1 → bytes EB 9F 77 81 B7 34 CA 72 A7 19, ks_index 0..9, done after the 10th byte.
- KEY_BYTES=5, key=40'h0102030405, MSG_LEN=8 → bytes B2 39 63 05 F0 3D C0 27. First ks_valid exactly 1286 cycles after start.
- Same as the first case with ks_ready toggled pseudo-randomly → identical byte sequence, no drops or duplicates, and ks_data/ks_index held during stalls.
- Assert reset 500 cycles into the KSA, release it, then restart → all outputs 0 during reset, and the keystream after restart matches the first case.
- start held high through DONE → done stays 1 with no restart. Dropping start returns to IDLE, and reasserting start begins a new run.
- INIT_S=0 with the RAM model preloaded with S[n]=n → identical keystream to the first case, with first ks_valid at 1030 cycles.
